tx_pkt_fifo: RTL and testbench

Single-clock, packet-aware transmit FIFO, the successor to the dual-clock byte FIFO on the mux transmit path. Packets are written speculatively and become visible to the reader only when their last beat is committed. Packets that overflow, or that the writer aborts, are discarded in full, so the downstream framer never sees a partial packet. The read side is first-word-fall-through with a valid flag, and the block reports committed-packet count, almost-full and almost-empty status.

---
 rtl/tx_pkt_fifo_pkg.sv | 12 +
 rtl/tx_pkt_fifo_ram.sv | 24 ++
 rtl/tx_pkt_fifo.sv | 145 ++++++++++++++
 tb/tb_tx_pkt_fifo.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkt_fifo_pkg.sv
// Shared types and constants for the packet-aware transmit FIFO.
package tx_pkt_fifo_pkg;

    typedef enum logic {
        ACCEPT  = 1'b0,
        DISCARD = 1'b1
    } wr_state_t;

    // Pointers carry one extra bit beyond the address so full and empty are distinguishable.
    localparam int PTR_EXT_BITS = 1;

endpackage

// File: rtl/tx_pkt_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module tx_pkt_fifo_ram #(
    parameter int WIDTH      = 9,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tx_pkt_fifo.sv
// Packet-aware transmit FIFO: speculative writes, commit on last beat,
// whole-packet discard on overflow or abort, first-word-fall-through read.
module tx_pkt_fifo
    import tx_pkt_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int PTR_WIDTH    = 10,
    parameter int AFULL_MARGIN = 16,
    parameter int AEMPTY_LVL   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_wlast,
    input  logic                  i_wabort,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_rlast,
    output logic                  o_rvalid,
    output logic                  o_full,
    output logic                  o_afull,
    output logic                  o_aempty,
    output logic [PTR_WIDTH:0]    o_pkt_cnt,
    output logic                  o_ovf
);

    localparam int LW = PTR_WIDTH + PTR_EXT_BITS;
    localparam logic [LW-1:0] DEPTH_L  = LW'(2 ** PTR_WIDTH);
    localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_MARGIN);
    localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_LVL);
    localparam logic [LW-1:0] ONE      = LW'(1);

    wr_state_t                state, state_nxt;
    logic [LW-1:0]            wr_ptr, wr_ptr_nxt;
    logic [LW-1:0]            wr_cmt, wr_cmt_nxt;
    logic [LW-1:0]            rd_ptr;
    logic [PTR_WIDTH:0]       pkt_cnt;
    logic                     ovf, ovf_nxt;
    logic                     wr_en;
    logic                     commit;
    logic                     pop_en;
    logic                     pop_last;
    logic [LW-1:0]            spec_lvl;
    logic [LW-1:0]            cmt_lvl;
    logic [LW-1:0]            free;
    logic                     full;
    logic                     rvalid;
    logic [DATA_WIDTH:0]      rd_word;

    tx_pkt_fifo_ram #(
        .WIDTH      (DATA_WIDTH + 1),
        .ADDR_WIDTH (PTR_WIDTH)
    ) u_ram (
        .clk   (i_clk),
        .we    (wr_en),
        .waddr (wr_ptr[PTR_WIDTH-1:0]),
        .wdata ({i_wlast, i_wdata}),
        .raddr (rd_ptr[PTR_WIDTH-1:0]),
        .rdata (rd_word)
    );

    assign spec_lvl = wr_ptr - rd_ptr;
    assign cmt_lvl  = wr_cmt - rd_ptr;
    assign free     = DEPTH_L - spec_lvl;
    assign full     = (spec_lvl == DEPTH_L);
    assign rvalid   = (rd_ptr != wr_cmt);
    assign pop_en   = i_pop && rvalid;
    assign pop_last = pop_en && rd_word[DATA_WIDTH];

    // Abort wins over everything; a push into a full FIFO rewinds to the last commit.
    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        wr_cmt_nxt = wr_cmt;
        ovf_nxt    = 1'b0;
        wr_en      = 1'b0;
        commit     = 1'b0;
        if (i_wabort) begin
            wr_ptr_nxt = wr_cmt;
            state_nxt  = ACCEPT;
        end else if (i_push) begin
            case (state)
                ACCEPT: begin
                    if (!full) begin
                        wr_en      = 1'b1;
                        wr_ptr_nxt = wr_ptr + ONE;
                        if (i_wlast) begin
                            wr_cmt_nxt = wr_ptr + ONE;
                            commit     = 1'b1;
                        end
                    end else begin
                        wr_ptr_nxt = wr_cmt;
                        if (i_wlast) begin
                            ovf_nxt = 1'b1;
                        end else begin
                            state_nxt = DISCARD;
                        end
                    end
                end
                DISCARD: begin
                    if (i_wlast) begin
                        ovf_nxt   = 1'b1;
                        state_nxt = ACCEPT;
                    end
                end
                default: state_nxt = ACCEPT;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= ACCEPT;
            wr_ptr  <= '0;
            wr_cmt  <= '0;
            rd_ptr  <= '0;
            pkt_cnt <= '0;
            ovf     <= 1'b0;
        end else begin
            state  <= state_nxt;
            wr_ptr <= wr_ptr_nxt;
            wr_cmt <= wr_cmt_nxt;
            ovf    <= ovf_nxt;
            if (pop_en) begin
                rd_ptr <= rd_ptr + ONE;
            end
            if (commit && !pop_last) begin
                pkt_cnt <= pkt_cnt + (PTR_WIDTH + 1)'(1);
            end else if (pop_last && !commit) begin
                pkt_cnt <= pkt_cnt - (PTR_WIDTH + 1)'(1);
            end
        end
    end

    assign o_rvalid  = rvalid;
    assign o_rdata   = rvalid ? rd_word[DATA_WIDTH-1:0] : '0;
    assign o_rlast   = rvalid && rd_word[DATA_WIDTH];
    assign o_full    = full;
    assign o_afull   = (free <= AFULL_L);
    assign o_aempty  = (cmt_lvl <= AEMPTY_L);
    assign o_pkt_cnt = pkt_cnt;
    assign o_ovf     = ovf;

endmodule

// File: tb/tb_tx_pkt_fifo.sv
// Randomized and directed bench for tx_pkt_fifo against a queue-based packet model.
module tb_tx_pkt_fifo;

    localparam int DW    = 8;
    localparam int PW    = 4;
    localparam int DEPTH = 16;
    localparam int AFM   = 2;
    localparam int AEL   = 2;

    logic          clk;
    logic          i_rst_n;
    logic          i_push;
    logic [DW-1:0] i_wdata;
    logic          i_wlast;
    logic          i_wabort;
    logic          i_pop;
    logic [DW-1:0] o_rdata;
    logic          o_rlast;
    logic          o_rvalid;
    logic          o_full;
    logic          o_afull;
    logic          o_aempty;
    logic [PW:0]   o_pkt_cnt;
    logic          o_ovf;

    int n_tests  = 0;
    int n_fail   = 0;
    int ovf_seen = 0;

    tx_pkt_fifo #(
        .DATA_WIDTH   (DW),
        .PTR_WIDTH    (PW),
        .AFULL_MARGIN (AFM),
        .AEMPTY_LVL   (AEL)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (i_rst_n),
        .i_push    (i_push),
        .i_wdata   (i_wdata),
        .i_wlast   (i_wlast),
        .i_wabort  (i_wabort),
        .i_pop     (i_pop),
        .o_rdata   (o_rdata),
        .o_rlast   (o_rlast),
        .o_rvalid  (o_rvalid),
        .o_full    (o_full),
        .o_afull   (o_afull),
        .o_aempty  (o_aempty),
        .o_pkt_cnt (o_pkt_cnt),
        .o_ovf     (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: cq holds visible beats {last,data}; sq holds the packet being written.
    logic [8:0] cq[$];
    logic [8:0] sq[$];
    bit         disc  = 1'b0;
    bit         m_ovf = 1'b0;

    always @(posedge clk) begin
        bit m_full;
        bit do_pop;
        if (!i_rst_n) begin
            cq.delete();
            sq.delete();
            disc  = 1'b0;
            m_ovf = 1'b0;
        end else begin
            m_full = ((cq.size() + sq.size()) == DEPTH);
            do_pop = i_pop && (cq.size() > 0);
            m_ovf  = 1'b0;
            if (i_wabort) begin
                sq.delete();
                disc = 1'b0;
            end else if (i_push) begin
                if (disc) begin
                    if (i_wlast) begin
                        m_ovf = 1'b1;
                        disc  = 1'b0;
                    end
                end else if (m_full) begin
                    sq.delete();
                    if (i_wlast) m_ovf = 1'b1;
                    else         disc  = 1'b1;
                end else begin
                    sq.push_back({i_wlast, i_wdata});
                    if (i_wlast) begin
                        foreach (sq[k]) cq.push_back(sq[k]);
                        sq.delete();
                    end
                end
            end
            if (do_pop) void'(cq.pop_front());
        end
    end

    always @(negedge clk) begin
        int lvl;
        int pkts;
        logic [8:0] head;
        lvl  = cq.size() + sq.size();
        pkts = 0;
        foreach (cq[k]) if (cq[k][8]) pkts++;
        head = (cq.size() > 0) ? cq[0] : 9'h000;
        chk("rvalid", o_rvalid, (cq.size() > 0));
        chk("rdata", o_rdata, head[7:0]);
        chk("rlast", o_rlast, head[8]);
        chk("full", o_full, (lvl == DEPTH));
        chk("afull", o_afull, ((DEPTH - lvl) <= AFM));
        chk("aempty", o_aempty, (cq.size() <= AEL));
        chk("pkt_cnt", o_pkt_cnt, pkts);
        chk("ovf", o_ovf, m_ovf);
        if (o_ovf === 1'b1) ovf_seen++;
    end

    task automatic step(input bit push, input logic [7:0] d, input bit last,
                        input bit abort, input bit pop);
        i_push   = push;
        i_wdata  = d;
        i_wlast  = last;
        i_wabort = abort;
        i_pop    = pop;
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (o_rvalid === 1'b1 && n < 64) begin
            step(0, 8'h00, 0, 0, 1);
            n++;
        end
        chk("drain_empty", o_rvalid, 1'b0);
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_push = 1'b0; i_wdata = '0; i_wlast = 1'b0; i_wabort = 1'b0; i_pop = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            step($urandom % 2, 8'($urandom), $urandom % 2, $urandom % 2, $urandom % 2);
        end
        chk("rst_rvalid", o_rvalid, 0);
        chk("rst_aempty", o_aempty, 1);
        chk("rst_pkt_cnt", o_pkt_cnt, 0);
        chk("rst_full", o_full, 0);
        i_rst_n = 1'b1;
        step(0, 8'h00, 0, 0, 0);

        // Basic packet
        step(1, 8'h11, 0, 0, 0);
        step(1, 8'h22, 0, 0, 0);
        chk("basic_hidden", o_rvalid, 0);
        step(1, 8'h33, 1, 0, 0);
        chk("basic_visible", o_rvalid, 1);
        chk("basic_cnt1", o_pkt_cnt, 1);
        chk("basic_head", o_rdata, 8'h11);
        step(0, 8'h00, 0, 0, 1);
        chk("basic_d2", o_rdata, 8'h22);
        chk("basic_l2", o_rlast, 0);
        step(0, 8'h00, 0, 0, 1);
        chk("basic_d3", o_rdata, 8'h33);
        chk("basic_l3", o_rlast, 1);
        step(0, 8'h00, 0, 0, 1);
        chk("basic_cnt0", o_pkt_cnt, 0);

        // Overflow: 20 beats, last on beat 20
        for (int b = 1; b <= 20; b++) begin
            step(1, 8'(b), (b == 20), 0, 0);
            if (b == 13) chk("ovf_afull13", o_afull, 0);
            if (b == 14) chk("ovf_afull14", o_afull, 1);
            if (b == 16) chk("ovf_full16", o_full, 1);
            if (b == 17) chk("ovf_rewind17", o_full, 0);
            if (b == 20) chk("ovf_pulse", o_ovf, 1);
        end
        step(0, 8'h00, 0, 0, 0);
        chk("ovf_pulse_end", o_ovf, 0);
        step(1, 8'h5A, 1, 0, 0);
        chk("ovf_next_head", o_rdata, 8'h5A);
        chk("ovf_next_last", o_rlast, 1);
        drain();

        // Abort with simultaneous push
        for (int b = 0; b < 4; b++) step(1, 8'(8'h40 + b), 0, 0, 0);
        step(1, 8'h99, 1, 1, 0);
        chk("abort_hidden", o_rvalid, 0);
        step(1, 8'hA5, 1, 0, 0);
        chk("abort_head", o_rdata, 8'hA5);
        chk("abort_last", o_rlast, 1);
        chk("abort_cnt", o_pkt_cnt, 1);
        drain();

        // Mid-packet reset
        step(1, 8'h71, 0, 0, 0);
        step(1, 8'h72, 1, 0, 0);
        step(1, 8'h73, 0, 0, 0);
        i_rst_n = 1'b0;
        step(1, 8'h74, 0, 0, 0);
        i_rst_n = 1'b1;
        chk("midrst_rvalid", o_rvalid, 0);
        chk("midrst_cnt", o_pkt_cnt, 0);
        step(1, 8'h75, 1, 0, 0);
        chk("midrst_head", o_rdata, 8'h75);
        drain();

        // Wrap-around: 10 packets of 5 beats with random pops
        for (int p = 0; p < 10; p++) begin
            int b = 0;
            while (b < 5) begin
                if (o_afull === 1'b1 || ($urandom % 4) == 0) begin
                    step(0, 8'h00, 0, 0, 1);
                end else begin
                    step(1, 8'($urandom), (b == 4), 0, ($urandom % 2));
                    b++;
                end
            end
        end
        drain();

        // Commit B while popping last beat of A
        step(1, 8'hC1, 0, 0, 0);
        step(1, 8'hC2, 1, 0, 0);
        chk("sim_cnt_a", o_pkt_cnt, 1);
        step(1, 8'hD1, 0, 0, 1);
        step(1, 8'hD2, 1, 0, 1);
        chk("sim_cnt_same", o_pkt_cnt, 1);
        chk("sim_head_b", o_rdata, 8'hD1);
        drain();

        // Push while full with a same-cycle pop
        for (int b = 0; b < 16; b++) step(1, 8'(8'h80 + b), (b == 15), 0, 0);
        chk("sfull_full", o_full, 1);
        step(1, 8'hEE, 0, 0, 1);
        chk("sfull_rejected", o_full, 0);
        step(1, 8'hEF, 0, 0, 0);
        chk("sfull_discard", o_full, 0);
        step(1, 8'hF0, 1, 0, 0);
        chk("sfull_ovf", o_ovf, 1);
        drain();
        chk("ovf_count", ovf_seen, 2);

        // Random soak
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) != 0, 8'($urandom), ($urandom % 5) == 0,
                 ($urandom % 40) == 0, (i < 300) ? (($urandom % 3) == 0) : (($urandom % 4) != 0));
        end
        step(0, 8'h00, 0, 1, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
